// File: rtl/universal_register.sv
// universal_register: WIDTH-bit general-purpose datapath register.
// Supports hold, parallel load, logical shifts with serial inputs, rotates,
// increment and decrement. The carry flag is registered and the zero flag is
// combinational from the register contents.
module universal_register #(
  parameter int unsigned            WIDTH     = 4,
  parameter logic [WIDTH-1:0]       RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] qout,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] qout_q;
  logic [WIDTH-1:0] qout_d;
  logic             carry_q;
  logic             carry_d;

  // Next-state selection: en low holds everything; otherwise op picks the result.
  always_comb begin
    qout_d  = qout_q;
    carry_d = carry_q;
    if (en) begin
      case (op)
        OP_HOLD: begin
          qout_d  = qout_q;
          carry_d = carry_q;
        end
        OP_LOAD: begin
          qout_d  = din;
          carry_d = 1'b0;
        end
        OP_SHL: begin
          qout_d  = {qout_q[WIDTH-2:0], sin_r};
          carry_d = qout_q[WIDTH-1];
        end
        OP_SHR: begin
          qout_d  = {sin_l, qout_q[WIDTH-1:1]};
          carry_d = qout_q[0];
        end
        OP_ROL: begin
          qout_d  = {qout_q[WIDTH-2:0], qout_q[WIDTH-1]};
          carry_d = qout_q[WIDTH-1];
        end
        OP_ROR: begin
          qout_d  = {qout_q[0], qout_q[WIDTH-1:1]};
          carry_d = qout_q[0];
        end
        OP_INC: begin
          // Wraps modulo 2^WIDTH; carry flags the all-ones to zero wrap.
          qout_d  = qout_q + ONE_VAL;
          carry_d = &qout_q;
        end
        OP_DEC: begin
          // Wraps modulo 2^WIDTH; carry acts as borrow on the zero to all-ones wrap.
          qout_d  = qout_q - ONE_VAL;
          carry_d = ~|qout_q;
        end
        default: begin
          qout_d  = qout_q;
          carry_d = carry_q;
        end
      endcase
    end else begin
      qout_d  = qout_q;
      carry_d = carry_q;
    end
  end

  // State register with synchronous reset taking priority over en and op.
  always_ff @(posedge clk) begin
    if (rst) begin
      qout_q  <= RESET_VAL;
      carry_q <= 1'b0;
    end else begin
      qout_q  <= qout_d;
      carry_q <= carry_d;
    end
  end

  assign qout  = qout_q;
  assign carry = carry_q;
  assign zero  = (qout_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_universal_register.sv
// Directed, table-driven bench for universal_register: a 4-bit instance
// (RESET_VAL=0), a 4-bit instance with RESET_VAL=1010 and an 8-bit instance.
module tb_universal_register;

  logic       clk;
  logic       rst, en, sin_r, sin_l;
  logic [2:0] op;
  logic [3:0] din;
  logic [3:0] q4, q4r;
  logic       c4, z4, c4r, z4r;

  logic       rst8, en8, sin_r8, sin_l8;
  logic [2:0] op8;
  logic [7:0] din8, q8;
  logic       c8, z8;

  int n_tests;
  int n_fail;

  universal_register #(.WIDTH(4), .RESET_VAL(4'b0000)) u4 (
    .clk(clk), .rst(rst), .en(en), .op(op), .din(din),
    .sin_r(sin_r), .sin_l(sin_l), .qout(q4), .carry(c4), .zero(z4)
  );

  universal_register #(.WIDTH(4), .RESET_VAL(4'b1010)) u4r (
    .clk(clk), .rst(rst), .en(en), .op(op), .din(din),
    .sin_r(sin_r), .sin_l(sin_l), .qout(q4r), .carry(c4r), .zero(z4r)
  );

  universal_register #(.WIDTH(8), .RESET_VAL(8'h00)) u8 (
    .clk(clk), .rst(rst8), .en(en8), .op(op8), .din(din8),
    .sin_r(sin_r8), .sin_l(sin_l8), .qout(q8), .carry(c8), .zero(z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [3:0] din;
    logic       sin_r;
    logic       sin_l;
    logic [3:0] exp_q;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive 4-bit controls on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step4(input logic r, input logic e, input logic [2:0] o,
                       input logic [3:0] d, input logic sr, input logic sl);
    @(negedge clk);
    rst = r; en = e; op = o; din = d; sin_r = sr; sin_l = sl;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic r, input logic e, input logic [2:0] o,
                       input logic [7:0] d, input logic sr);
    @(negedge clk);
    rst8 = r; en8 = e; op8 = o; din8 = d; sin_r8 = sr; sin_l8 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; en = 1'b0; op = 3'b000; din = 4'b0000; sin_r = 1'b0; sin_l = 1'b0;
    rst8 = 1'b1; en8 = 1'b0; op8 = 3'b000; din8 = 8'h00; sin_r8 = 1'b0; sin_l8 = 1'b0;

    //                name          rst   en    op      din      sr    sl    q        c     z
    vecs.push_back('{"reset",       1'b1, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{"en0_load",    1'b0, 1'b0, 3'b001, 4'b0111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{"load_0111",   1'b0, 1'b1, 3'b001, 4'b0111, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0});
    vecs.push_back('{"shl_sr1",     1'b0, 1'b1, 3'b010, 4'b0000, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0});
    vecs.push_back('{"shr_sl0",     1'b0, 1'b1, 3'b011, 4'b0000, 1'b0, 1'b0, 4'b0111, 1'b1, 1'b0});
    vecs.push_back('{"load2_0111",  1'b0, 1'b1, 3'b001, 4'b0111, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0});
    vecs.push_back('{"ror",         1'b0, 1'b1, 3'b101, 4'b0000, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b0});
    vecs.push_back('{"rol",         1'b0, 1'b1, 3'b100, 4'b0000, 1'b0, 1'b0, 4'b0111, 1'b1, 1'b0});
    vecs.push_back('{"load_1110",   1'b0, 1'b1, 3'b001, 4'b1110, 1'b0, 1'b0, 4'b1110, 1'b0, 1'b0});
    vecs.push_back('{"inc_to_f",    1'b0, 1'b1, 3'b110, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0});
    vecs.push_back('{"inc_wrap",    1'b0, 1'b1, 3'b110, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1});
    vecs.push_back('{"dec_wrap",    1'b0, 1'b1, 3'b111, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0});
    vecs.push_back('{"dec_to_e",    1'b0, 1'b1, 3'b111, 4'b0000, 1'b0, 1'b0, 4'b1110, 1'b0, 1'b0});
    vecs.push_back('{"en0_dec",     1'b0, 1'b0, 3'b111, 4'b0000, 1'b0, 1'b0, 4'b1110, 1'b0, 1'b0});
    vecs.push_back('{"rol_msb1",    1'b0, 1'b1, 3'b100, 4'b0000, 1'b0, 1'b0, 4'b1101, 1'b1, 1'b0});
    vecs.push_back('{"hold_op",     1'b0, 1'b1, 3'b000, 4'b0101, 1'b1, 1'b1, 4'b1101, 1'b1, 1'b0});
    vecs.push_back('{"en0_load_c",  1'b0, 1'b0, 3'b001, 4'b0000, 1'b0, 1'b0, 4'b1101, 1'b1, 1'b0});
    vecs.push_back('{"shr_sl1",     1'b0, 1'b1, 3'b011, 4'b0000, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0});
    vecs.push_back('{"shl_sr0",     1'b0, 1'b1, 3'b010, 4'b1111, 1'b0, 1'b1, 4'b1100, 1'b1, 1'b0});
    vecs.push_back('{"inc_noc",     1'b0, 1'b1, 3'b110, 4'b0000, 1'b0, 1'b0, 4'b1101, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      step4(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].din, vecs[i].sin_r, vecs[i].sin_l);
      check({vecs[i].name, "_q"}, {28'd0, q4}, {28'd0, vecs[i].exp_q});
      check({vecs[i].name, "_c"}, {31'd0, c4}, {31'd0, vecs[i].exp_c});
      check({vecs[i].name, "_z"}, {31'd0, z4}, {31'd0, vecs[i].exp_z});
    end

    // Reset in the middle of an INC run, on both 4-bit instances.
    step4(1'b1, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);
    check("rv_reset_q", {28'd0, q4r}, {28'd0, 4'b1010});
    check("rv_reset_z", {31'd0, z4r}, {31'd0, 1'b0});
    step4(1'b0, 1'b1, 3'b001, 4'b0101, 1'b0, 1'b0);
    check("mid_load_q", {28'd0, q4}, {28'd0, 4'b0101});
    step4(1'b0, 1'b1, 3'b110, 4'b0000, 1'b0, 1'b0);
    step4(1'b0, 1'b1, 3'b110, 4'b0000, 1'b0, 1'b0);
    check("mid_inc2_q", {28'd0, q4}, {28'd0, 4'b0111});
    check("mid_inc2_rv", {28'd0, q4r}, {28'd0, 4'b0111});
    step4(1'b1, 1'b1, 3'b110, 4'b0000, 1'b0, 1'b0);
    check("mid_rst_q", {28'd0, q4}, {28'd0, 4'b0000});
    check("mid_rst_c", {31'd0, c4}, {31'd0, 1'b0});
    check("mid_rst_z", {31'd0, z4}, {31'd0, 1'b1});
    check("mid_rst_rv_q", {28'd0, q4r}, {28'd0, 4'b1010});
    check("mid_rst_rv_z", {31'd0, z4r}, {31'd0, 1'b0});
    check("mid_rst_rv_c", {31'd0, c4r}, {31'd0, 1'b0});
    step4(1'b0, 1'b1, 3'b110, 4'b0000, 1'b0, 1'b0);
    check("post_rst_inc", {28'd0, q4}, {28'd0, 4'b0001});
    check("post_rst_rv_inc", {28'd0, q4r}, {28'd0, 4'b1011});

    // Reset pulse between edges must be ignored.
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("glitch_rst_q", {28'd0, q4}, {28'd0, 4'b0001});

    // 8-bit instance: shift-out into carry, then borrow wrap and carry wrap.
    step8(1'b1, 1'b0, 3'b000, 8'h00, 1'b0);
    check("w8_reset_z", {31'd0, z8}, {31'd0, 1'b1});
    step8(1'b0, 1'b1, 3'b001, 8'h80, 1'b0);
    check("w8_load_q", {24'd0, q8}, {24'd0, 8'h80});
    step8(1'b0, 1'b1, 3'b010, 8'h00, 1'b0);
    check("w8_shl_q", {24'd0, q8}, {24'd0, 8'h00});
    check("w8_shl_c", {31'd0, c8}, {31'd0, 1'b1});
    check("w8_shl_z", {31'd0, z8}, {31'd0, 1'b1});
    step8(1'b0, 1'b1, 3'b111, 8'h00, 1'b0);
    check("w8_dec_q", {24'd0, q8}, {24'd0, 8'hFF});
    check("w8_dec_c", {31'd0, c8}, {31'd0, 1'b1});
    check("w8_dec_z", {31'd0, z8}, {31'd0, 1'b0});
    step8(1'b0, 1'b1, 3'b110, 8'h00, 1'b0);
    check("w8_inc_q", {24'd0, q8}, {24'd0, 8'h00});
    check("w8_inc_c", {31'd0, c8}, {31'd0, 1'b1});
    step8(1'b0, 1'b1, 3'b101, 8'h00, 1'b0);
    check("w8_ror_c", {31'd0, c8}, {31'd0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
Parametrised successor to the team's plain enabled 4-bit register. It is a WIDTH-bit storage register with an operation select: hold, parallel load, logical shift left/right with serial inputs, rotate left/right, increment and decrement. It also has a registered carry/borrow flag and a zero flag. It is the general-purpose datapath register for the lab designs (accumulators, shifters, counters).

Parameters:
WIDTH, 4, data width in bits (legal range 2..32)
RESET_VAL, 0, value loaded into qout on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  operation enable; 0 = all state held
op  input  3  operation select (encoding below)
din  input  WIDTH  parallel load data
sin_r  input  1  serial bit entering bit 0 on shift left
sin_l  input  1  serial bit entering bit WIDTH-1 on shift right
qout  output  WIDTH  register contents
carry  output  1  registered carry/borrow/shifted-out bit
zero  output  1  1 when qout == 0 (combinational from qout)

Behaviour:
- Single clock domain. All state (qout, carry) updates only on the rising edge of clk.
- Reset:
  - rst=1 at a rising edge sets qout <= RESET_VAL and carry <= 0.
  - Reset has priority over en and op.
  - rst is not sampled between edges. A pulse that does not span a rising edge has no effect.
- en=0 (rst=0): qout and carry hold, regardless of op.
- en=1 (rst=0): one operation per edge, 1-cycle latency. The result is visible on qout after the edge.
- op encoding (Q = qout before the edge, W = WIDTH):
  - 000 HOLD: qout <= Q; carry holds.
  - 001 LOAD: qout <= din; carry <= 0.
  - 010 SHL: qout <= {Q[W-2:0], sin_r}; carry <= Q[W-1].
  - 011 SHR: qout <= {sin_l, Q[W-1:1]}; carry <= Q[0].
  - 100 ROL: qout <= {Q[W-2:0], Q[W-1]}; carry <= Q[W-1].
  - 101 ROR: qout <= {Q[0], Q[W-1:1]}; carry <= Q[0].
  - 110 INC: qout <= Q + 1 modulo 2^W.
    - carry <= 1 when Q is all-ones (wrap to 0), else 0.
  - 111 DEC: qout <= Q - 1 modulo 2^W.
    - carry <= 1 when Q == 0 (borrow, wrap to all-ones), else 0.
- Arithmetic is unsigned, W bits. No saturation; wrap-around is required.
- zero reflects the current qout combinationally. Immediately after reset it equals (RESET_VAL == 0).
- din, sin_l and sin_r are ignored unless the selected op uses them.
- Changing op or din between edges has no effect. Only the values sampled at the edge matter.
- Reset mid-sequence (for example during repeated INC) discards the sequence. The next edge with rst=0 operates on RESET_VAL.
- X/undefined op values are not supported. The bench drives only legal encodings.

Test Plan:
(WIDTH=4, RESET_VAL=0 unless stated)
1. rst=1 for one edge, then en=0, op=001, din=0111, one edge -> qout=0000, carry=0, zero=1 (enable gating).
2. en=1, op=001, din=0111 -> qout=0111, zero=0. Then op=010, sin_r=1 -> qout=1111, carry=0. Then op=011, sin_l=0 -> qout=0111, carry=1.
3. Load 0111, op=101 (ROR) -> qout=1011, carry=1. Then op=100 (ROL) -> qout=0111, carry=1.
4. Load 1110, op=110 twice -> 1111 (carry=0), then 0000 (carry=1, zero=1). Then op=111 -> 1111, carry=1. Then op=111 -> 1110, carry=0.
5. Load 0101, INC for 2 edges, assert rst=1 with en=1, op=110 on the 3rd edge -> qout=0000, carry=0. Repeat with RESET_VAL=1010 -> qout=1010, zero=0.
6. WIDTH=8 instance: load 8'h80, op=010, sin_r=0 -> qout=8'h00, carry=1, zero=1. Then op=111 -> 8'hFF, carry=1.
